// File: rtl/opq_capture.sv
// opq_capture: registered change/rising-edge capture stage for the o/p/q cone.
// Samples {o,p,q} on enabled cycles and counts rising edges per output with
// saturating counters. Every change is queued as an {old,new} record in a
// first-word-fall-through FIFO that a valid/ready consumer drains.
//
// Handshake: a record transfers on a rising clk edge where out_valid and
// out_ready are both high. out_valid never depends on out_ready.
// out_data/out_valid hold steady while out_valid=1 and out_ready=0.
module opq_capture #(
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     o,
  input  logic                     p,
  input  logic                     q,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [5:0]               out_data,
  output logic [CNT_W-1:0]         cnt_o,
  output logic [CNT_W-1:0]         cnt_p,
  output logic [CNT_W-1:0]         cnt_q,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    UNPRIMED = 1'b0,
    RUN      = 1'b1
  } state_t;

  state_t            state;
  logic [2:0]        cur;
  logic [2:0]        s_opq;
  logic [2:0]        rise;
  logic              sample;
  logic              change;
  logic              full;
  logic              pop;
  logic              push;
  logic [5:0]        mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNT_W-1:0]  cnt [3];

  // Bit 2 is o, bit 1 is p, bit 0 is q throughout.
  assign cur       = {o, p, q};
  assign sample    = en && (state == RUN);
  assign change    = sample && (cur != s_opq);
  assign rise      = cur & ~s_opq;
  assign full      = (level == LW'(DEPTH));
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts a record when the head leaves on the same edge.
  assign push      = change && (!full || pop);
  assign out_data  = out_valid ? mem[rd_ptr] : 6'd0;
  assign state_dbg = (state == RUN);

  assign cnt_o = cnt[2];
  assign cnt_p = cnt[1];
  assign cnt_q = cnt[0];

  // Prime on the first enabled cycle, then track the last sample while enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= UNPRIMED;
      s_opq <= 3'b000;
    end else if (en) begin
      state <= RUN;
      s_opq <= cur;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Record storage; contents are only visible through out_data when valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_opq, cur};
  end

  // Saturating rising-edge counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else if (sample) begin
      for (int i = 0; i < 3; i++) begin
        if (rise[i] && (cnt[i] != {CNT_W{1'b1}})) cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  // Sticky drop flag; clear wins over a same-cycle drop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (clr) begin
      overflow <= 1'b0;
    end else if (change && !push) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_opq_capture.sv
// tb_opq_capture: directed and random stimulus against a queue-based model.
// Two instances share all inputs: default counters (CNT_W=8) and narrow
// counters (CNT_W=2) so saturation is exercised alongside normal counting.
module tb_opq_capture;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic en, clr, o, p, q, out_ready;

  always #5 clk = ~clk;

  logic       v1, ov1, st1;
  logic [5:0] d1;
  logic [7:0] co1, cp1, cq1;
  logic [2:0] lv1;

  logic       v2, ov2, st2;
  logic [5:0] d2;
  logic [1:0] co2, cp2, cq2;
  logic [2:0] lv2;

  opq_capture #(.CNT_W(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .o(o), .p(p), .q(q),
    .out_valid(v1), .out_ready(out_ready), .out_data(d1),
    .cnt_o(co1), .cnt_p(cp1), .cnt_q(cq1), .overflow(ov1), .level(lv1),
    .state_dbg(st1)
  );

  opq_capture #(.CNT_W(2), .DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .o(o), .p(p), .q(q),
    .out_valid(v2), .out_ready(out_ready), .out_data(d2),
    .cnt_o(co2), .cnt_p(cp2), .cnt_q(cq2), .overflow(ov2), .level(lv2),
    .state_dbg(st2)
  );

  // ---------------- reference model ----------------
  int         checks = 0;
  int         failures = 0;
  bit         primed;
  logic [2:0] ms;
  logic [5:0] exp_q[$];
  int         rc[3];
  bit         movf;

  function automatic int sat(input int raw, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (raw > mx) ? mx : raw;
  endfunction

  task automatic model_reset();
    primed = 1'b0;
    ms = 3'b000;
    exp_q.delete();
    for (int i = 0; i < 3; i++) rc[i] = 0;
    movf = 1'b0;
  endtask

  // One rising edge worth of behaviour, using the inputs present at the edge.
  task automatic model_step();
    logic [2:0] cur;
    cur = {o, p, q};
    if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    if (en) begin
      if (!primed) begin
        primed = 1'b1;
      end else if (cur != ms) begin
        for (int i = 0; i < 3; i++) if (!ms[i] && cur[i]) rc[i]++;
        if (exp_q.size() < DEPTH) exp_q.push_back({ms, cur});
        else movf = 1'b1;
      end
      ms = cur;
    end
    if (clr) begin
      for (int i = 0; i < 3; i++) rc[i] = 0;
      movf = 1'b0;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [5:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : 6'd0;
    chk("valid",    v1,  exp_q.size() != 0);
    chk("data",     d1,  head);
    chk("level",    lv1, exp_q.size());
    chk("cnt_o",    co1, sat(rc[2], 8));
    chk("cnt_p",    cp1, sat(rc[1], 8));
    chk("cnt_q",    cq1, sat(rc[0], 8));
    chk("overflow", ov1, movf);
    chk("state",    st1, primed);
    chk("valid2",   v2,  exp_q.size() != 0);
    chk("data2",    d2,  head);
    chk("level2",   lv2, exp_q.size());
    chk("cnt_o2",   co2, sat(rc[2], 2));
    chk("cnt_p2",   cp2, sat(rc[1], 2));
    chk("cnt_q2",   cq2, sat(rc[0], 2));
    chk("overflow2", ov2, movf);
  endtask

  // ---------------- driver ----------------
  task automatic cycle();
    @(posedge clk);
    if (rst) model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input bit e, input bit c, input logic [2:0] v, input bit r);
    en = e;
    clr = c;
    {o, p, q} = v;
    out_ready = r;
    cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    en = 1'b0; clr = 1'b0; o = 1'b0; p = 1'b0; q = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) cycle();
    rst = 1'b1;

    // Priming: steady 101 gives nothing.
    repeat (3) drive(1, 0, 3'b101, 1);
    chk("t1_level", lv1, 0);
    chk("t1_cnt_o", co1, 0);

    // Single change 101 -> 011.
    drive(1, 0, 3'b011, 1);
    chk("t2_data", d1, 6'b101011);
    chk("t2_cnt_p", cp1, 1);
    drive(1, 0, 3'b011, 1);
    chk("t2_valid_after_pop", v1, 0);

    // Five changes with consumer stalled: fifth record is dropped.
    drive(1, 0, 3'b000, 0);
    drive(1, 0, 3'b111, 0);
    drive(1, 0, 3'b010, 0);
    drive(1, 0, 3'b101, 0);
    drive(1, 0, 3'b110, 0);
    chk("t3_level", lv1, 4);
    chk("t3_overflow", ov1, 1);
    chk("t3_head", d1, 6'b011000);
    repeat (4) drive(0, 0, 3'b110, 1);
    drive(0, 1, 3'b110, 0);
    chk("t3_ovf_clr", ov1, 0);
    chk("t3_cnt_clr", co1, 0);

    // Saturation of the narrow counter, then clear beating a rising o.
    drive(1, 0, 3'b010, 1);
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 3'b110, 1);
      drive(1, 0, 3'b010, 1);
    end
    chk("t4_sat", co2, 3);
    chk("t4_wide", co1, 5);
    drive(1, 1, 3'b110, 1);
    chk("t4_clr_wins", co2, 0);
    repeat (2) drive(1, 0, 3'b110, 1);

    // Full FIFO: push accepted when the head pops on the same edge.
    drive(1, 0, 3'b000, 0);
    drive(1, 0, 3'b001, 0);
    drive(1, 0, 3'b011, 0);
    drive(1, 0, 3'b111, 0);
    chk("t5_full", lv1, 4);
    drive(1, 0, 3'b101, 1);
    chk("t5_level", lv1, 4);
    chk("t5_ovf", ov1, 0);
    repeat (3) drive(0, 0, 3'b101, 1);
    chk("t5_last", d1, 6'b111101);
    drive(0, 0, 3'b101, 1);

    // Asynchronous reset with three records queued.
    drive(1, 0, 3'b100, 0);
    drive(1, 0, 3'b000, 0);
    drive(1, 0, 3'b010, 0);
    chk("t6_level3", lv1, 3);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("t6_async_valid", v1, 0);
    #1 rst = 1'b1;
    drive(1, 0, 3'b111, 0);
    chk("t6_reprime_level", lv1, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
